display_capture: RTL and testbench

Receive-side monitor for the 8-digit multiplexed seven-segment bus: watches the segment lines a–g and the anode enables aa7–aa0, decodes each digit as its anode window is scanned, and presents the recovered 4-bit hex value of all eight digits once a complete scan frame has been seen. It sits on the far end of the display pins: in loopback on the board for self-test, or in the bench as the checker for the display path. Segments and anodes are active-low, matching the board's display wiring.

---
 rtl/display_pkg.sv | 32 +++
 rtl/display_if.sv | 24 ++
 rtl/seg7_to_hex.sv | 35 +++
 rtl/display_capture.sv | 169 ++++++++++++++++
 tb/tb_display_capture.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants for the seven-segment capture path: legal segment codes
// (abcdefg, 0 = lit), window FSM states and the SETTLE limits.
package display_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_SAMPLE,
    ST_HOLD
  } win_state_t;

endpackage

// File: rtl/display_if.sv
// Display pin bundle plus recovered-digit outputs; master drives the pins,
// slave (the capture block) watches them and reports the decoded frame.
interface display_if;

  logic       a, b, c, d, e, f, g;
  logic       aa7, aa6, aa5, aa4, aa3, aa2, aa1, aa0;
  logic [3:0] D7, D6, D5, D4, D3, D2, D1, D0;
  logic       frame_valid, frame_done, seg_err, multi_err;

  modport master (
    output a, b, c, d, e, f, g,
    output aa7, aa6, aa5, aa4, aa3, aa2, aa1, aa0,
    input  D7, D6, D5, D4, D3, D2, D1, D0,
    input  frame_valid, frame_done, seg_err, multi_err
  );

  modport slave (
    input  a, b, c, d, e, f, g,
    input  aa7, aa6, aa5, aa4, aa3, aa2, aa1, aa0,
    output D7, D6, D5, D4, D3, D2, D1, D0,
    output frame_valid, frame_done, seg_err, multi_err
  );

endinterface

// File: rtl/seg7_to_hex.sv
// Combinational lookup from an active-low abcdefg pattern to its hex value;
// valid drops for any pattern outside the sixteen legal glyphs.
module seg7_to_hex
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] hex
);

  always_comb begin
    valid = 1'b1;
    hex   = 4'h0;
    case (seg)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Multiplexed seven-segment bus monitor: one sample per settled anode window.
// states: IDLE no window | COUNT settling | SAMPLE decode latched segs | HOLD window already sampled
module display_capture
  import display_pkg::*;
#(
  parameter int SETTLE = 16,
  parameter bit SYNC   = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  display_if.slave bus
);

  localparam int SETTLE_C = (SETTLE < SETTLE_MIN) ? SETTLE_MIN :
                            (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_C - 1);

  logic [14:0] pins, pins_s;
  assign pins = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g,
                 bus.aa7, bus.aa6, bus.aa5, bus.aa4, bus.aa3, bus.aa2, bus.aa1, bus.aa0};

  generate
    if (SYNC) begin : g_sync
      logic [14:0] meta, stable;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          meta   <= '1;
          stable <= '1;
        end else begin
          meta   <= pins;
          stable <= meta;
        end
      end
      assign pins_s = stable;
    end else begin : g_direct
      assign pins_s = pins;
    end
  endgenerate

  logic [6:0] seg;
  logic [7:0] act;
  logic [2:0] k_now;
  logic       is_one, is_multi;

  assign seg      = pins_s[14:8];
  assign act      = ~pins_s[7:0];
  assign is_one   = (act != 8'h00) && ((act & (act - 8'd1)) == 8'h00);
  assign is_multi = (act != 8'h00) && !is_one;

  always_comb begin
    k_now = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (act[i]) k_now = 3'(i);
    end
  end

  win_state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [2:0] k, k_nxt;
  logic [6:0] seg_q, seg_q_nxt;
  logic       same;

  assign same = is_one && (k_now == k);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      k     <= '0;
      seg_q <= '1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      k     <= k_nxt;
      seg_q <= seg_q_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    k_nxt     = k;
    seg_q_nxt = seg_q;
    case (state)
      ST_COUNT: begin
        if (same) begin
          if (cnt == 8'd0) begin
            state_nxt = ST_SAMPLE;
            seg_q_nxt = seg;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
      end
      ST_SAMPLE, ST_HOLD: begin
        if (same) state_nxt = ST_HOLD;
      end
      default: ;
    endcase
    // any classification other than the remembered ONE(k) starts over, as from IDLE
    if (state == ST_IDLE || !same) begin
      if (is_one) begin
        state_nxt = ST_COUNT;
        k_nxt     = k_now;
        cnt_nxt   = CNT_LOAD;
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  logic       dec_valid;
  logic [3:0] dec_hex;

  seg7_to_hex u_dec (
    .seg   (seg_q),
    .valid (dec_valid),
    .hex   (dec_hex)
  );

  logic       wr, frame_full;
  logic [3:0] shadow [8];
  logic [3:0] d_q    [8];
  logic [7:0] seen;
  logic       multi_prev, frame_valid_q, frame_done_q, seg_err_q, multi_err_q;

  assign wr         = (state == ST_SAMPLE) && dec_valid;
  assign frame_full = (seen == 8'hFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        d_q[i]    <= '0;
      end
      seen          <= '0;
      multi_prev    <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      seg_err_q     <= 1'b0;
      multi_err_q   <= 1'b0;
    end else begin
      if (wr) shadow[k] <= dec_hex;
      seen          <= (frame_full ? 8'h00 : seen) | (wr ? (8'h01 << k) : 8'h00);
      seg_err_q     <= (state == ST_SAMPLE) && !dec_valid;
      multi_prev    <= is_multi;
      multi_err_q   <= is_multi && !multi_prev;
      frame_done_q  <= frame_full;
      if (frame_full) begin
        for (int i = 0; i < 8; i++) d_q[i] <= shadow[i];
        frame_valid_q <= 1'b1;
      end
    end
  end

  assign bus.D0 = d_q[0];
  assign bus.D1 = d_q[1];
  assign bus.D2 = d_q[2];
  assign bus.D3 = d_q[3];
  assign bus.D4 = d_q[4];
  assign bus.D5 = d_q[5];
  assign bus.D6 = d_q[6];
  assign bus.D7 = d_q[7];
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.multi_err   = multi_err_q;

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture: scans hand-picked frames over the pin
// bundle and compares recovered digits and pulse counts with fixed expectations.
`timescale 1ns/1ps
module tb_display_capture;

  localparam int SETTLE = 16;
  localparam int WIN    = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  display_if dif ();

  display_capture #(.SETTLE(SETTLE), .SYNC(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int n_seg    = 0;
  int n_multi  = 0;

  always @(negedge clk) begin
    if (dif.frame_done === 1'b1) n_done++;
    if (dif.seg_err === 1'b1)    n_seg++;
    if (dif.multi_err === 1'b1)  n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [6:0] code_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [31:0] d_all();
    return {dif.D7, dif.D6, dif.D5, dif.D4, dif.D3, dif.D2, dif.D1, dif.D0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input logic [7:0] an, input logic [6:0] segv);
    {dif.a, dif.b, dif.c, dif.d, dif.e, dif.f, dif.g} = segv;
    {dif.aa7, dif.aa6, dif.aa5, dif.aa4, dif.aa3, dif.aa2, dif.aa1, dif.aa0} = an;
  endtask

  task automatic window(input int k, input logic [6:0] segv, input int len, input int gap);
    set_pins(~(8'h01 << k), segv);
    tick(len);
    if (gap > 0) begin
      set_pins(8'hFF, 7'h7F);
      tick(gap);
    end
  endtask

  task automatic scan_frame(input logic [31:0] val, input int gap);
    for (int k = 0; k < 8; k++) window(k, code_of(val[4*k +: 4]), WIN, gap);
  endtask

  int base_done, base_seg, base_multi;

  initial begin
    reset = 1'b0;
    set_pins(8'hFF, 7'h7F);
    tick(3);
    reset = 1'b1;
    tick(2);
    check("rst_d", d_all(), 32'h0);
    check("rst_valid", {31'h0, dif.frame_valid}, 32'h0);
    check("rst_pulses", {29'h0, dif.frame_done, dif.seg_err, dif.multi_err}, 32'h0);

    // partial frame discarded by reset
    for (int k = 0; k < 5; k++) window(k, code_of(4'(8 - k)), WIN, 2);
    #2 reset = 1'b0;
    tick(3);
    check("midrst_d", d_all(), 32'h0);
    check("midrst_valid", {31'h0, dif.frame_valid}, 32'h0);
    reset = 1'b1;
    tick(2);
    base_done = n_done;
    scan_frame(32'h9ABCDEF0, 2);
    tick(6);
    check("midrst_done", 32'(n_done - base_done), 32'd1);
    check("midrst_frame", d_all(), 32'h9ABCDEF0);
    check("midrst_valid2", {31'h0, dif.frame_valid}, 32'h1);

    // full scan, frame completes only on the eighth window
    base_done = n_done;
    for (int k = 0; k < 7; k++) window(k, code_of(4'(8 - k)), WIN, 0);
    check("full_early", 32'(n_done - base_done), 32'd0);
    window(7, code_of(4'h1), WIN, 2);
    tick(4);
    check("full_done", 32'(n_done - base_done), 32'd1);
    check("full_frame", d_all(), 32'h12345678);

    // digit 3 held only SETTLE cycles, then SETTLE+1
    base_done = n_done;
    for (int k = 0; k < 8; k++) window(k, code_of(4'(k + 1)), (k == 3) ? SETTLE : WIN, 2);
    tick(4);
    check("short_nodone", 32'(n_done - base_done), 32'd0);
    check("short_keep", d_all(), 32'h12345678);
    window(3, code_of(4'h4), SETTLE + 1, 2);
    tick(4);
    check("short_done", 32'(n_done - base_done), 32'd1);
    check("short_frame", d_all(), 32'h87654321);

    // blank pattern on digit 5
    base_done = n_done;
    base_seg  = n_seg;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] v;
      v = 32'h13579BDF;
      window(k, (k == 5) ? 7'h7F : code_of(v[4*k +: 4]), WIN, 2);
    end
    tick(4);
    check("blank_segerr", 32'(n_seg - base_seg), 32'd1);
    check("blank_nodone", 32'(n_done - base_done), 32'd0);
    window(5, code_of(4'h5), WIN, 2);
    tick(4);
    check("blank_done", 32'(n_done - base_done), 32'd1);
    check("blank_frame", d_all(), 32'h13579BDF);

    // aa2 and aa6 together for 10 cycles
    base_done  = n_done;
    base_multi = n_multi;
    set_pins(~8'h44, code_of(4'h8));
    tick(10);
    set_pins(8'hFF, 7'h7F);
    tick(4);
    check("multi_pulse", 32'(n_multi - base_multi), 32'd1);
    check("multi_nodone", 32'(n_done - base_done), 32'd0);
    scan_frame(32'h2468ACE0, 2);
    tick(4);
    check("multi_recover", 32'(n_done - base_done), 32'd1);
    check("multi_frame", d_all(), 32'h2468ACE0);

    // back-to-back frames with no idle gap
    base_done = n_done;
    scan_frame(32'h00000000, 0);
    check("b2b_done1", 32'(n_done - base_done), 32'd1);
    check("b2b_frame1", d_all(), 32'h00000000);
    scan_frame(32'hFFFFFFFF, 0);
    set_pins(8'hFF, 7'h7F);
    tick(6);
    check("b2b_done2", 32'(n_done - base_done), 32'd2);
    check("b2b_frame2", d_all(), 32'hFFFFFFFF);
    check("no_stray_seg", 32'(n_seg - base_seg), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
